de4_sopc_st_width_adapter_32to8: RTL and testbench
==================================================

Name: de4_sopc_st_width_adapter_32to8

Overview:
- Avalon-ST data-format adapter directly downstream of the SOPC timing adapter.
- Consumes its 32-bit, 4-symbol beats (sop/eop/error/empty) and serialises them into 8-bit, 1-symbol beats for a byte-wide packet sink.
- Ready latency 0 on both sides; symbol 0 is in the MSBs, so data[31:24] is emitted first.
- Also monitors input framing and flags protocol violations.

Parameters:
- SYMBOL_W, 8, bits per symbol.
- IN_SYMBOLS, 4, symbols per input beat; must be a power of 2.
- EMPTY_W, 2, log2(IN_SYMBOLS), width of in_empty.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_ready  out  1  sink ready, ready latency 0.
- in_valid  in  1  input beat valid.
- in_data  in  32  4 symbols, symbol 0 in [31:24].
- in_error  in  1  beat error.
- in_startofpacket  in  1  first beat of packet.
- in_endofpacket  in  1  last beat of packet.
- in_empty  in  2  unused LSB-end symbols; honoured only when in_endofpacket=1.
- out_ready  in  1  downstream ready, ready latency 0.
- out_valid  out  1  output byte valid.
- out_data  out  8  current symbol.
- out_error  out  1  error of the originating beat.
- out_startofpacket  out  1  first byte of packet.
- out_endofpacket  out  1  last valid byte of packet.
- framing_error  out  1  sticky protocol-violation flag.
- clear_status  in  1  synchronous clear of framing_error.

Behaviour:
- State: hold_valid, hold_data[31:0], hold_sop, hold_eop, hold_err, byte_idx[1:0], last_idx[1:0], in_pkt.
- Reset (async, reset_n=0): hold_valid, byte_idx, in_pkt and framing_error go to 0.
  - Outputs during reset: out_valid=0, out_sop=0, out_eop=0, out_error=0, out_data=0.
  - in_ready is forced 0 while reset_n=0.
- Input fire = in_valid & in_ready.
- Output fire = out_valid & out_ready.
- last_idx on load = in_endofpacket ? (3 - in_empty) : 3.
  - in_empty=3 with eop is legal and gives a single byte.
- in_ready = !hold_valid | (out_ready & byte_idx==last_idx).
  - This is a combinational path from out_ready; full throughput is 1 byte/cycle with no bubble between beats.
- Output signals:
  - out_valid = hold_valid.
  - out_data = hold_data byte selected by byte_idx: idx 0 gives [31:24], idx 3 gives [7:0].
  - out_startofpacket = hold_sop & byte_idx==0.
  - out_endofpacket = hold_eop & byte_idx==last_idx.
  - out_error = hold_err, repeated on every byte of the beat.
- Per clock edge:
  - If output fire and byte_idx != last_idx: byte_idx increments.
  - If output fire and byte_idx == last_idx: byte_idx clears to 0; if input fires in the same cycle, load the new beat, otherwise hold_valid clears.
  - If hold_valid=0 and input fires: load the beat, byte_idx=0, hold_valid=1.
  - Load and drain in the same cycle is required; no beat or byte may be lost or duplicated.
- Output stall: with out_valid=1 and out_ready=0, out_data, out_valid, out_sop, out_eop and out_error are held stable.
- Framing monitor, evaluated on input fire only:
  - in_pkt is set on sop and cleared on eop; sop&eop together is a single-beat packet and leaves in_pkt=0.
  - framing_error sets on:
    - sop while in_pkt=1.
    - a beat without sop while in_pkt=0.
  - Offending beats are still forwarded unchanged; the monitor is observational only.
  - If set and clear_status fire in the same cycle, set wins.
- Reset mid-packet: the held beat and remaining bytes are discarded with no eop emitted; the next packet must start with sop.

Decomposition:
- Shared package de4_sopc_st_pkg:
  - SYMBOL_W and IN_SYMBOLS constants.
  - Byte-lane index type (logic [EMPTY_W-1:0]).
  - Function last_lane(eop, empty).
- One natural sub-module, de4_sopc_st_framing_monitor: in_pkt / framing_error logic on the input fire strobe.
- The datapath (holding register, lane mux, counters) stays in the top.

Test Plan:
- Single beat, data=0xA1B2C3D4, sop=eop=1, empty=0, out_ready=1 -> bytes A1,B2,C3,D4 on 4 consecutive cycles; sop on A1, eop on D4; in_ready=1 on D4's cycle.
- 3-beat packet 0x00010203, 0x04050607, 0x08090A0B with empty=2 on the eop beat, out_ready=1 continuous -> 10 bytes 00..09 back-to-back with no gap; eop on 09; 0A and 0B are never output.
- eop beat with empty=3, data=0xEE000000 -> one byte EE carrying both sop and eop (if sop set) in a single cycle.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_data/out_valid stable while stalled; in_ready=0 until the last lane fires; byte order intact.
- Error beat, in_error=1 mid-packet -> out_error=1 on all 4 bytes of that beat only.
- Framing: two sop beats without an intervening eop -> framing_error=1 the cycle after the 2nd fire, data still forwarded; clear_status -> 0. Also reset_n pulsed low mid-beat -> out_valid=0 immediately (async), framing_error=0, and the next packet is output cleanly.

Source files
------------

// File: rtl/de4_sopc_st_pkg.sv
`default_nettype none
// ==================================================================
// de4_sopc_st_pkg -- shared widths, lane index type, last-lane helper
// Rev 1.0
// ==================================================================
package de4_sopc_st_pkg;

  localparam int SYMBOL_W   = 8;
  localparam int IN_SYMBOLS = 4;
  localparam int EMPTY_W    = $clog2(IN_SYMBOLS);
  localparam int DATA_W     = SYMBOL_W * IN_SYMBOLS;

  typedef logic [EMPTY_W-1:0] lane_t;

  localparam lane_t c_LANE_MAX = lane_t'(IN_SYMBOLS - 1);

  // Index of the final meaningful lane of a beat; empty only counts on eop.
  function automatic lane_t last_lane(input logic eop, input lane_t empty);
    return eop ? lane_t'(c_LANE_MAX - empty) : c_LANE_MAX;
  endfunction

endpackage : de4_sopc_st_pkg
`default_nettype wire

// File: rtl/de4_sopc_st_width_adapter_32to8_if.sv
`default_nettype none
// ==================================================================
// de4_sopc_st_width_adapter_32to8_if -- wide sink / byte source bus
// Rev 1.0
// ==================================================================
interface de4_sopc_st_width_adapter_32to8_if;
  import de4_sopc_st_pkg::*;

  logic                in_ready;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_error;
  logic                in_startofpacket;
  logic                in_endofpacket;
  lane_t               in_empty;

  logic                out_ready;
  logic                out_valid;
  logic [SYMBOL_W-1:0] out_data;
  logic                out_error;
  logic                out_startofpacket;
  logic                out_endofpacket;

  // Adapter side.
  modport slave (
    output in_ready,
    input  in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
    input  out_ready,
    output out_valid, out_data, out_error, out_startofpacket, out_endofpacket
  );

  // Environment side: upstream source plus downstream sink.
  modport master (
    input  in_ready,
    output in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty,
    output out_ready,
    input  out_valid, out_data, out_error, out_startofpacket, out_endofpacket
  );

endinterface : de4_sopc_st_width_adapter_32to8_if
`default_nettype wire

// File: rtl/de4_sopc_st_framing_monitor.sv
`default_nettype none
// ==================================================================
// de4_sopc_st_framing_monitor -- sticky sop/eop framing violation flag
// Rev 1.0
// ==================================================================
module de4_sopc_st_framing_monitor (
  input  logic clk,
  input  logic reset_n,
  input  logic i_fire,
  input  logic i_sop,
  input  logic i_eop,
  input  logic i_clear,
  output logic o_framing_error
);

  logic r_in_pkt;
  logic r_framing_error;
  logic w_violation;

  // A sop must open a packet; any other beat must continue one.
  assign w_violation = i_fire & (i_sop ? r_in_pkt : ~r_in_pkt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_pkt        <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      if (i_fire) begin
        if (i_eop) begin
          r_in_pkt <= 1'b0;
        end else if (i_sop) begin
          r_in_pkt <= 1'b1;
        end
      end
      if (w_violation) begin
        r_framing_error <= 1'b1;
      end else if (i_clear) begin
        r_framing_error <= 1'b0;
      end
    end
  end

  assign o_framing_error = r_framing_error;

endmodule : de4_sopc_st_framing_monitor
`default_nettype wire

// File: rtl/de4_sopc_st_width_adapter_32to8.sv
`default_nettype none
// ==================================================================
// de4_sopc_st_width_adapter_32to8 -- 4-symbol beats to 1-symbol beats
// Rev 1.0
// ==================================================================
module de4_sopc_st_width_adapter_32to8
  import de4_sopc_st_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset_n,
  de4_sopc_st_width_adapter_32to8_if.slave    st,
  input  logic                                clear_status,
  output logic                                framing_error
);

  logic                r_hold_valid;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_hold_sop;
  logic                r_hold_eop;
  logic                r_hold_err;
  lane_t               r_byte_idx;
  lane_t               r_last_idx;

  logic                w_at_last;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [SYMBOL_W-1:0] w_lane [IN_SYMBOLS];

  // Symbol 0 sits in the MSBs and is emitted first.
  generate
    for (genvar g = 0; g < IN_SYMBOLS; g++) begin : g_lane
      assign w_lane[g] = r_hold_data[(IN_SYMBOLS-1-g)*SYMBOL_W +: SYMBOL_W];
    end
  endgenerate

  assign w_at_last  = (r_byte_idx == r_last_idx);
  assign w_out_fire = r_hold_valid & st.out_ready;

  // Accept the next beat in the same cycle the last lane leaves, so beats
  // stream with no bubble; held low throughout reset.
  assign st.in_ready = reset_n & (~r_hold_valid | (st.out_ready & w_at_last));
  assign w_in_fire   = st.in_valid & st.in_ready;

  assign st.out_valid         = r_hold_valid;
  assign st.out_data          = w_lane[r_byte_idx];
  assign st.out_startofpacket = r_hold_sop & (r_byte_idx == '0);
  assign st.out_endofpacket   = r_hold_eop & w_at_last;
  assign st.out_error         = r_hold_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_sop   <= 1'b0;
      r_hold_eop   <= 1'b0;
      r_hold_err   <= 1'b0;
      r_byte_idx   <= '0;
      r_last_idx   <= '0;
    end else if (w_in_fire) begin
      // in_ready guarantees the holding register is empty or draining now.
      r_hold_valid <= 1'b1;
      r_hold_data  <= st.in_data;
      r_hold_sop   <= st.in_startofpacket;
      r_hold_eop   <= st.in_endofpacket;
      r_hold_err   <= st.in_error;
      r_byte_idx   <= '0;
      r_last_idx   <= last_lane(st.in_endofpacket, st.in_empty);
    end else if (w_out_fire) begin
      if (w_at_last) begin
        r_hold_valid <= 1'b0;
        r_byte_idx   <= '0;
      end else begin
        r_byte_idx   <= r_byte_idx + lane_t'(1);
      end
    end
  end

  de4_sopc_st_framing_monitor u_framing_monitor (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_fire          (w_in_fire),
    .i_sop           (st.in_startofpacket),
    .i_eop           (st.in_endofpacket),
    .i_clear         (clear_status),
    .o_framing_error (framing_error)
  );

endmodule : de4_sopc_st_width_adapter_32to8
`default_nettype wire

// File: tb/tb_de4_sopc_st_width_adapter_32to8.sv
`default_nettype none
// ==================================================================
// tb_de4_sopc_st_width_adapter_32to8 -- byte-queue reference model bench
// Rev 1.0
// ==================================================================
module tb_de4_sopc_st_width_adapter_32to8;
  import de4_sopc_st_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic       r;
  } obyte_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [1:0]  empty;
    int          exp_n;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic clear_status;
  logic framing_error;

  de4_sopc_st_width_adapter_32to8_if bus();

  de4_sopc_st_width_adapter_32to8 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .st            (bus.slave),
    .clear_status  (clear_status),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  obyte_t q[$];
  obyte_t got[$];
  int     out_cyc[$];
  logic   m_inpkt;
  logic   m_ferr;
  logic   last_in_fire;
  vec_t   vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge with inputs settled; checks outputs against the
  // expected byte stream, updates the model, then waits for the next negedge.
  task automatic cycle();
    logic inf, outf, exp_rdy, viol;
    int   n;
    #1;
    inf     = bus.in_valid & bus.in_ready;
    outf    = bus.out_valid & bus.out_ready;
    exp_rdy = reset_n && (q.size() == 0 || (q.size() == 1 && bus.out_ready));
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
    chk("framing_error", {31'd0, framing_error}, {31'd0, m_ferr});
    if (q.size() != 0) begin
      chk("out_data", {24'd0, bus.out_data}, {24'd0, q[0].d});
      chk("out_sop", {31'd0, bus.out_startofpacket}, {31'd0, q[0].s});
      chk("out_eop", {31'd0, bus.out_endofpacket}, {31'd0, q[0].e});
      chk("out_error", {31'd0, bus.out_error}, {31'd0, q[0].r});
    end
    if (reset_n) begin
      if (outf && q.size() != 0) begin
        got.push_back(q[0]);
        out_cyc.push_back(cyc);
        q.delete(0);
      end
      if (inf) begin
        n = bus.in_endofpacket ? 4 - int'(bus.in_empty) : 4;
        for (int k = 0; k < n; k++) begin
          q.push_back('{d: 8'(bus.in_data >> (24 - 8 * k)),
                        s: bus.in_startofpacket && k == 0,
                        e: bus.in_endofpacket && k == n - 1,
                        r: bus.in_error});
        end
      end
      viol = inf && (bus.in_startofpacket ? m_inpkt : !m_inpkt);
      if (inf) m_inpkt = bus.in_endofpacket ? 1'b0 : (bus.in_startofpacket ? 1'b1 : m_inpkt);
      m_ferr = viol ? 1'b1 : (clear_status ? 1'b0 : m_ferr);
    end
    last_in_fire = inf;
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e,
                      input logic r, input logic [1:0] emp);
    bus.in_data          = d;
    bus.in_startofpacket = s;
    bus.in_endofpacket   = e;
    bus.in_error         = r;
    bus.in_empty         = emp;
    bus.in_valid         = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (last_in_fire) break;
    end
    chk("send_accepted", {31'd0, last_in_fire}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && q.size() != 0; i++) cycle();
    chk("drained", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int total;
    logic gen_inpkt;
    logic [7:0] bp_exp [4];

    vecs[0] = '{32'hA1B2C3D4, 1'b1, 1'b1, 1'b0, 2'd0, 4, 8'hA1, 8'hD4};
    vecs[1] = '{32'h00010203, 1'b1, 1'b0, 1'b0, 2'd0, 4, 8'h00, 8'h03};
    vecs[2] = '{32'h04050607, 1'b0, 1'b0, 1'b0, 2'd3, 4, 8'h04, 8'h07};
    vecs[3] = '{32'h08090A0B, 1'b0, 1'b1, 1'b0, 2'd2, 2, 8'h08, 8'h09};
    vecs[4] = '{32'hEE000000, 1'b1, 1'b1, 1'b0, 2'd3, 1, 8'hEE, 8'hEE};
    vecs[5] = '{32'h55667788, 1'b1, 1'b0, 1'b0, 2'd0, 4, 8'h55, 8'h88};
    vecs[6] = '{32'h99AABBCC, 1'b0, 1'b0, 1'b1, 2'd0, 4, 8'h99, 8'hCC};
    vecs[7] = '{32'hDDEEFF00, 1'b0, 1'b1, 1'b0, 2'd1, 3, 8'hDD, 8'hFF};

    reset_n = 1'b0; clear_status = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_error = 1'b0;
    bus.in_startofpacket = 1'b0; bus.in_endofpacket = 1'b0; bus.in_empty = '0;
    bus.out_ready = 1'b1;
    m_inpkt = 1'b0; m_ferr = 1'b0; last_in_fire = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_sop", {31'd0, bus.out_startofpacket}, 32'd0);
    chk("rst_out_eop", {31'd0, bus.out_endofpacket}, 32'd0);
    chk("rst_out_error", {31'd0, bus.out_error}, 32'd0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();

    // Table vectors streamed back to back with out_ready held high
    got.delete(); out_cyc.delete();
    total = 0;
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].sop, vecs[i].eop, vecs[i].err, vecs[i].empty);
      total += vecs[i].exp_n;
    end
    drain();
    chk("stream_len", got.size(), total);
    if (out_cyc.size() != 0) chk("no_gap", out_cyc[$] - out_cyc[0] + 1, total);
    idx = 0;
    foreach (vecs[i]) begin
      if (idx + vecs[i].exp_n <= got.size()) begin
        chk($sformatf("v%0d_first", i), {24'd0, got[idx].d}, {24'd0, vecs[i].exp_first});
        chk($sformatf("v%0d_last", i), {24'd0, got[idx + vecs[i].exp_n - 1].d}, {24'd0, vecs[i].exp_last});
        chk($sformatf("v%0d_sop", i), {31'd0, got[idx].s}, {31'd0, vecs[i].sop});
        chk($sformatf("v%0d_eop", i), {31'd0, got[idx + vecs[i].exp_n - 1].e}, {31'd0, vecs[i].eop});
        chk($sformatf("v%0d_err", i), {31'd0, got[idx + vecs[i].exp_n - 1].r}, {31'd0, vecs[i].err});
      end
      idx += vecs[i].exp_n;
    end
    chk("table_ferr", {31'd0, framing_error}, 32'd0);

    // Backpressure: out_ready pattern 1,0,0 repeating
    got.delete();
    bus.in_data = 32'h12345678; bus.in_startofpacket = 1'b1; bus.in_endofpacket = 1'b1;
    bus.in_error = 1'b0; bus.in_empty = 2'd0; bus.in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.out_ready = (i % 3 == 0);
      cycle();
      if (last_in_fire) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    drain();
    bp_exp = '{8'h12, 8'h34, 8'h56, 8'h78};
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp_byte%0d", i), {24'd0, got[i].d}, {24'd0, bp_exp[i]});

    // Framing: repeated sop, then clear; then set beats clear in same cycle
    send(32'h10111213, 1'b1, 1'b0, 1'b0, 2'd0);
    send(32'h20212223, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("ferr_set", {31'd0, framing_error}, 32'd1);
    send(32'h30313233, 1'b0, 1'b1, 1'b0, 2'd0);
    drain();
    clear_status = 1'b1;
    cycle();
    clear_status = 1'b0;
    chk("ferr_cleared", {31'd0, framing_error}, 32'd0);
    clear_status = 1'b1;
    send(32'h40414243, 1'b0, 1'b0, 1'b0, 2'd0);
    clear_status = 1'b0;
    chk("ferr_set_wins", {31'd0, framing_error}, 32'd1);
    drain();

    // Reset in the middle of a beat, then a clean packet
    send(32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 2'd0);
    cycle();
    reset_n = 1'b0;
    q.delete(); m_inpkt = 1'b0; m_ferr = 1'b0;
    cycle();
    chk("midrst_out_data", {24'd0, bus.out_data}, 32'd0);
    reset_n = 1'b1;
    got.delete();
    send(32'h0C0D0E0F, 1'b1, 1'b1, 1'b0, 2'd0);
    drain();
    chk("post_rst_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("post_rst_first", {24'd0, got[0].d}, 32'h0C);
      chk("post_rst_sop", {31'd0, got[0].s}, 32'd1);
      chk("post_rst_eop", {31'd0, got[3].e}, 32'd1);
    end
    chk("post_rst_ferr", {31'd0, framing_error}, 32'd0);

    // Random traffic against the byte-queue model
    gen_inpkt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.in_valid || last_in_fire) begin
        bus.in_valid         = ($urandom % 4) != 0;
        bus.in_data          = $urandom;
        bus.in_startofpacket = gen_inpkt ? (($urandom % 20) == 0) : (($urandom % 20) != 0);
        bus.in_endofpacket   = ($urandom % 3) == 0;
        bus.in_error         = ($urandom % 8) == 0;
        bus.in_empty         = 2'($urandom);
        if (bus.in_valid)
          gen_inpkt = bus.in_endofpacket ? 1'b0 : (bus.in_startofpacket ? 1'b1 : gen_inpkt);
      end
      bus.out_ready = ($urandom % 4) != 0;
      clear_status  = ($urandom % 16) == 0;
      cycle();
    end
    bus.in_valid = 1'b0; clear_status = 1'b0; bus.out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_de4_sopc_st_width_adapter_32to8
`default_nettype wire
